// File: rtl/plc_arb_pkg.sv
// plc_arb_pkg: arbitration mode constants and sequencing state encoding
package plc_arb_pkg;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR = 1;
  typedef enum logic [1:0] {IDLE, ARB, ISSUE} arb_state_e;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first set request searching base, base+1, ... modulo N_CH
module rr_priority_picker #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] base,
  output logic                    valid,
  output logic [$clog2(N_CH)-1:0] index
);
  localparam int IW = $clog2(N_CH);
  logic [IW-1:0] cand;
  assign valid = |req;
  // scanned farthest-first so the candidate nearest to base is written last
  always_comb begin
    index = '0;
    cand = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = IW'((int'(base) + k) % N_CH);
      if (req[cand]) index = cand;
    end
  end
endmodule

// File: rtl/multi_write_arbiter.sv
// multi_write_arbiter: buffers one write per thread channel and issues at most one RAM write per step
module multi_write_arbiter
  import plc_arb_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 1,
  parameter int ARB_MODE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arb_en,
  input  logic                     arb_step,
  input  logic [N_CH-1:0]          ch_we,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr,
  output logic [N_CH-1:0]          ch_ack,
  output logic [N_CH-1:0]          ch_pend,
  output logic                     ram_we,
  output logic [DATA_W-1:0]        ram_data,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [$clog2(N_CH)-1:0]  grant_id
);
  localparam int IW = $clog2(N_CH);
  logic [N_CH-1:0] pend, cap, clr, pend_nxt;
  logic [DATA_W-1:0] hold_data [N_CH];
  logic [ADDR_W-1:0] hold_addr [N_CH];
  logic [IW-1:0] ptr, base, w;
  logic valid, grant;
  arb_state_e state, state_nxt;
  assign base = ARB_MODE == ARB_RR ? ptr : '0;
  rr_priority_picker #(.N_CH(N_CH)) picker (
    .req(pend),
    .base(base),
    .valid(valid),
    .index(w)
  );
  // capture looks at pre-edge pend, so a request is never granted on its capture edge
  assign grant = arb_step & valid;
  assign cap = ch_we & ~pend & {N_CH{arb_en}};
  assign clr = grant ? {{(N_CH-1){1'b0}}, 1'b1} << w : '0;
  assign pend_nxt = (pend & ~clr) | cap;
  assign ch_pend = pend;
  assign ram_we = state == ISSUE;
  always_comb begin
    state_nxt = grant ? ISSUE : |pend_nxt ? ARB : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend <= '0;
      ch_ack <= '0;
      ram_data <= '0;
      ram_addr <= '0;
      grant_id <= '0;
      ptr <= '0;
    end else begin
      state <= state_nxt;
      pend <= pend_nxt;
      ch_ack <= clr;
      if (grant) begin
        ram_data <= hold_data[w];
        ram_addr <= hold_addr[w];
        grant_id <= w;
        ptr <= w == IW'(N_CH - 1) ? '0 : w + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        hold_data[i] <= '0;
        hold_addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cap[i]) begin
          hold_data[i] <= ch_data[i*DATA_W +: DATA_W];
          hold_addr[i] <= ch_addr[i*ADDR_W +: ADDR_W];
        end
      end
    end
  end
endmodule
